// File: rtl/processor_data_memory.sv
// Data-memory responder for the core's stage2 port: word RAM at the bottom of the
// address space plus an MMIO window (TX FIFO, RX holding register, cycle counter).
module processor_data_memory #(
    parameter int ADDR_SIZE       = 18,
    parameter int WORD_SIZE       = 18,
    parameter int RAM_ADDR_BITS   = 10,
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [ADDR_SIZE-1:0] memory_addr,
    input  logic                 memory_write_enable,
    input  logic                 memory_read_enable,
    input  logic [WORD_SIZE-1:0] memory_in,
    output logic [WORD_SIZE-1:0] memory_out,
    output logic [WORD_SIZE-1:0] tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    input  logic [WORD_SIZE-1:0] rx_data_in,
    input  logic                 rx_valid_in,
    output logic                 rx_ready
);
    localparam int RAM_DEPTH  = 1 << RAM_ADDR_BITS;
    localparam int FIFO_DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [ADDR_SIZE-1:0] MMIO_BASE   = ADDR_SIZE'((64'd1 << ADDR_SIZE) - 64'd256);
    localparam logic [ADDR_SIZE-1:0] ADDR_TX     = MMIO_BASE;
    localparam logic [ADDR_SIZE-1:0] ADDR_STATUS = MMIO_BASE + ADDR_SIZE'(1);
    localparam logic [ADDR_SIZE-1:0] ADDR_RX     = MMIO_BASE + ADDR_SIZE'(2);
    localparam logic [ADDR_SIZE-1:0] ADDR_CYCLE  = MMIO_BASE + ADDR_SIZE'(3);

    // Address decode
    logic sel_ram, sel_tx, sel_stat, sel_rx, sel_cyc;
    assign sel_ram  = (memory_addr[ADDR_SIZE-1:RAM_ADDR_BITS] == '0);
    assign sel_tx   = (memory_addr == ADDR_TX);
    assign sel_stat = (memory_addr == ADDR_STATUS);
    assign sel_rx   = (memory_addr == ADDR_RX);
    assign sel_cyc  = (memory_addr == ADDR_CYCLE);

    // RAM: no reset, read of the pre-edge contents goes through memory_out_q
    logic [WORD_SIZE-1:0] ram_q [RAM_DEPTH];
    logic [RAM_ADDR_BITS-1:0] ram_idx;
    assign ram_idx = memory_addr[RAM_ADDR_BITS-1:0];

    always_ff @(posedge clock) begin
        if (memory_write_enable && sel_ram) ram_q[ram_idx] <= memory_in;
    end

    // TX FIFO
    logic [WORD_SIZE-1:0]       fifo_q [FIFO_DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [FIFO_DEPTH_LOG2:0]   count_q, count_d;
    logic fifo_empty, fifo_full, pop, push_req, push;
    logic overflow_q, overflow_d;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == (FIFO_DEPTH_LOG2+1)'(FIFO_DEPTH));
    assign pop        = !fifo_empty && tx_ready;
    assign push_req   = memory_write_enable && sel_tx;
    // A full FIFO still takes the word when the head leaves in the same cycle
    assign push       = push_req && (!fifo_full || pop);

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) wptr_d = wptr_q + 1'b1;
        if (pop)  rptr_d = rptr_q + 1'b1;
        if (push && !pop) count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
        if (push_req && !push) overflow_d = 1'b1;
        else if (memory_write_enable && sel_stat && memory_in[3]) overflow_d = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (push) fifo_q[wptr_q] <= memory_in;
    end

    assign tx_data  = fifo_q[rptr_q];
    assign tx_valid = !fifo_empty;

    // RX holding register; accept and consume are mutually exclusive on rx_full
    logic [WORD_SIZE-1:0] rx_reg_q, rx_reg_d;
    logic rx_full_q, rx_full_d;

    always_comb begin
        rx_reg_d  = rx_reg_q;
        rx_full_d = rx_full_q;
        if (rx_valid_in && !rx_full_q) begin
            rx_reg_d  = rx_data_in;
            rx_full_d = 1'b1;
        end else if (memory_read_enable && sel_rx && rx_full_q) begin
            rx_full_d = 1'b0;
        end
    end

    assign rx_ready = !rx_full_q;

    // Cycle counter
    logic [WORD_SIZE-1:0] cycle_q, cycle_d;
    assign cycle_d = (memory_write_enable && sel_cyc) ? memory_in : cycle_q + 1'b1;

    // Read mux, all sources are pre-edge values
    logic [WORD_SIZE-1:0] rdata, status_word, memory_out_q, memory_out_d;
    assign status_word = WORD_SIZE'({overflow_q, rx_full_q, fifo_full, fifo_empty});

    always_comb begin
        rdata = '0;
        if (sel_ram)       rdata = ram_q[ram_idx];
        else if (sel_stat) rdata = status_word;
        else if (sel_rx)   rdata = rx_reg_q;
        else if (sel_cyc)  rdata = cycle_q;
    end

    assign memory_out_d = memory_read_enable ? rdata : memory_out_q;
    assign memory_out   = memory_out_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            rx_reg_q     <= '0;
            rx_full_q    <= 1'b0;
            cycle_q      <= '0;
            memory_out_q <= '0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            rx_reg_q     <= rx_reg_d;
            rx_full_q    <= rx_full_d;
            cycle_q      <= cycle_d;
            memory_out_q <= memory_out_d;
        end
    end
endmodule

// File: tb/tb_processor_data_memory.sv
// Scoreboard bench for processor_data_memory: stimulus queues expected load data and
// TX words; monitors compare them as the DUT presents memory_out and tx handshakes.
module tb_processor_data_memory;
    localparam logic [17:0] A_TX = 18'h3FF00, A_ST = 18'h3FF01, A_RX = 18'h3FF02, A_CY = 18'h3FF03;

    logic        clock = 1'b0, reset = 1'b1;
    logic [17:0] memory_addr = '0, memory_in = '0, rx_data_in = '0;
    logic        memory_write_enable = 1'b0, memory_read_enable = 1'b0;
    logic        tx_ready = 1'b0, rx_valid_in = 1'b0;
    logic [17:0] memory_out, tx_data;
    logic        tx_valid, rx_ready;

    processor_data_memory dut (
        .clock(clock), .reset(reset), .memory_addr(memory_addr),
        .memory_write_enable(memory_write_enable), .memory_read_enable(memory_read_enable),
        .memory_in(memory_in), .memory_out(memory_out), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data_in(rx_data_in),
        .rx_valid_in(rx_valid_in), .rx_ready(rx_ready)
    );

    always #5 clock = ~clock;

    int n_checks = 0, n_fail = 0;
    logic [17:0] rd_q [$];
    logic [17:0] tx_q [$];
    logic rd_pend = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Load-data monitor: a load issued at an edge is visible after it
    always @(posedge clock) rd_pend <= memory_read_enable && !reset;
    always @(negedge clock) begin
        if (rd_pend) begin
            if (rd_q.size() == 0) chk("unexpected load", 32'(memory_out), 32'hDEAD);
            else chk("load data", 32'(memory_out), 32'(rd_q.pop_front()));
        end
    end

    // TX monitor: a handshake seen before the edge pops the head at that edge
    always @(negedge clock) begin
        if (!reset && tx_valid && tx_ready) begin
            if (tx_q.size() == 0) chk("unexpected tx", 32'(tx_data), 32'hDEAD);
            else chk("tx word", 32'(tx_data), 32'(tx_q.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic idle();
        memory_write_enable = 1'b0;
        memory_read_enable  = 1'b0;
    endtask

    task automatic wr(input logic [17:0] a, input logic [17:0] d);
        memory_addr = a; memory_in = d; memory_write_enable = 1'b1; memory_read_enable = 1'b0;
        tick(); idle();
    endtask

    task automatic rd(input logic [17:0] a, input logic [17:0] exp);
        memory_addr = a; memory_read_enable = 1'b1; memory_write_enable = 1'b0;
        rd_q.push_back(exp);
        tick(); idle();
    endtask

    task automatic wrrd(input logic [17:0] a, input logic [17:0] d, input logic [17:0] exp);
        memory_addr = a; memory_in = d; memory_write_enable = 1'b1; memory_read_enable = 1'b1;
        rd_q.push_back(exp);
        tick(); idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick(); tick();
        chk("reset memory_out", 32'(memory_out), 0);
        chk("reset tx_valid", 32'(tx_valid), 0);
        chk("reset rx_ready", 32'(rx_ready), 1);
        reset = 1'b0;
        rd(A_ST, 18'h00001);

        // RAM write/read, same-word read+write returns old, unmapped address
        wr(18'd5, 18'h12345);
        rd(18'd5, 18'h12345);
        wr(18'd1023, 18'h00777);
        rd(18'd1023, 18'h00777);
        wrrd(18'd5, 18'h2AAAA, 18'h12345);
        rd(18'd5, 18'h2AAAA);
        wr(18'h20000, 18'h11111);
        rd(18'h20000, 18'h00000);
        rd(18'd1023, 18'h00777);
        tick(); tick();
        chk("memory_out hold", 32'(memory_out), 32'h00777);

        // TX overflow: five pushes into a four-entry FIFO
        for (int i = 1; i <= 5; i++) wr(A_TX, 18'(i));
        for (int i = 1; i <= 4; i++) tx_q.push_back(18'(i));
        rd(A_ST, 18'h0000A);
        rd(A_TX, 18'h00000);
        wr(A_ST, 18'h00008);
        rd(A_ST, 18'h00002);
        // Full FIFO with a pop in the same cycle accepts the push
        tx_ready = 1'b1;
        wr(A_TX, 18'h00055);
        tx_ready = 1'b0;
        tx_q.push_back(18'h00055);
        rd(A_ST, 18'h00002);
        tx_ready = 1'b1;
        repeat (6) tick();
        tx_ready = 1'b0;
        rd(A_ST, 18'h00001);

        // RX accept, consume, no same-cycle refill, stale read
        rx_data_in = 18'h00ABC; rx_valid_in = 1'b1;
        tick();
        rx_valid_in = 1'b0;
        chk("rx_ready after accept", 32'(rx_ready), 0);
        rd(A_ST, 18'h00005);
        memory_addr = A_RX; memory_read_enable = 1'b1;
        rx_data_in = 18'h00DEF; rx_valid_in = 1'b1;
        rd_q.push_back(18'h00ABC);
        chk("rx_ready in consume cycle", 32'(rx_ready), 0);
        tick(); idle();
        chk("rx_ready after consume", 32'(rx_ready), 1);
        tick();
        rx_valid_in = 1'b0;
        chk("rx_ready after refill", 32'(rx_ready), 0);
        rd(A_RX, 18'h00DEF);
        rd(A_RX, 18'h00DEF);
        rd(A_ST, 18'h00001);

        // Cycle counter load, wrap, write+read returns pre-edge value
        wr(A_CY, 18'h3FFFE);
        rd(A_CY, 18'h3FFFE);
        rd(A_CY, 18'h3FFFF);
        rd(A_CY, 18'h00000);
        wrrd(A_CY, 18'h00100, 18'h00001);
        rd(A_CY, 18'h00100);

        // Reset with FIFO holding three words and RX full
        for (int i = 0; i < 3; i++) wr(A_TX, 18'h00070 + 18'(i));
        rx_data_in = 18'h00123; rx_valid_in = 1'b1;
        tick();
        rx_valid_in = 1'b0;
        chk("tx_valid before reset", 32'(tx_valid), 1);
        reset = 1'b1;
        tick();
        chk("tx_valid after reset", 32'(tx_valid), 0);
        chk("rx_ready after reset", 32'(rx_ready), 1);
        chk("memory_out after reset", 32'(memory_out), 0);
        reset = 1'b0;
        rd(A_ST, 18'h00001);

        tick(); tick();
        chk("load queue drained", 32'(rd_q.size()), 0);
        chk("tx queue drained", 32'(tx_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
